// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling engine.
//   pool_mode_e  : reduction mode selected per window (MAX or AVG)
//   pool_state_e : control FSM states of the top level
//   sum_width()  : accumulator width able to hold the sum of a whole window
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } pool_state_e;

  // Summing SIZE signed W-bit values needs log2(SIZE) guard bits.
  function automatic int sum_width(input int w, input int size);
    return w + $clog2(size);
  endfunction

endpackage

// File: rtl/pool_channel.sv
// One pooling channel: reduces the LANES elements of a beat (max and sum)
// and folds them into a running accumulator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   lanes      : LANES elements of W bits, lane l at [l*W +: W]
//   first      : beat is the first of its window (seeds the accumulator)
//   mode       : reduction mode for this beat
//   en         : beat accepted this cycle
//   result     : window result computed from the post-update accumulator,
//                valid in the cycle the final beat is accepted
module pool_channel
  import pool_pkg::*;
#(
  parameter int W     = 20,
  parameter int LANES = 4,
  parameter int SIZE  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LANES*W-1:0] lanes,
  input  logic               first,
  input  pool_mode_e         mode,
  input  logic               en,
  output logic [W-1:0]       result
);

  localparam int AW = sum_width(W, SIZE);
  localparam int SH = $clog2(SIZE);

  logic signed [AW-1:0] acc_r;
  logic signed [AW-1:0] acc_nxt_s;
  logic signed [AW-1:0] lane_max_s;
  logic signed [AW-1:0] lane_sum_s;
  logic signed [AW-1:0] elem_s;
  logic signed [AW-1:0] avg_s;

  // Lane reduction: signed maximum and sign-extended sum of the beat.
  always_comb begin
    elem_s     = {{(AW-W){lanes[W-1]}}, lanes[W-1:0]};
    lane_max_s = elem_s;
    lane_sum_s = elem_s;
    for (int l = 1; l < LANES; l++) begin
      elem_s = {{(AW-W){lanes[l*W+W-1]}}, lanes[l*W +: W]};
      if (elem_s > lane_max_s) begin
        lane_max_s = elem_s;
      end else begin
        lane_max_s = lane_max_s;
      end
      lane_sum_s = lane_sum_s + elem_s;
    end
  end

  // Next accumulator value: the first beat seeds it (no zero floor for MAX).
  always_comb begin
    acc_nxt_s = acc_r;
    if (!en) begin
      acc_nxt_s = acc_r;
    end else begin
      case (mode)
        POOL_MAX: begin
          if (first || (lane_max_s > acc_r)) begin
            acc_nxt_s = lane_max_s;
          end else begin
            acc_nxt_s = acc_r;
          end
        end
        POOL_AVG: begin
          if (first) begin
            acc_nxt_s = lane_sum_s;
          end else begin
            acc_nxt_s = acc_r + lane_sum_s;
          end
        end
        default: acc_nxt_s = acc_r;
      endcase
    end
  end

  // Result: arithmetic shift divides by SIZE rounding toward -inf; the
  // quotient of an in-range sum is itself in range, so truncation is exact.
  always_comb begin
    avg_s = acc_nxt_s >>> SH;
    case (mode)
      POOL_MAX: result = acc_nxt_s[W-1:0];
      POOL_AVG: result = avg_s[W-1:0];
      default:  result = {W{1'b0}};
    endcase
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {AW{1'b0}};
    end else begin
      acc_r <= acc_nxt_s;
    end
  end

endmodule

// File: rtl/pooling_unit.sv
// Streaming multi-channel pooling engine. A window of SIZE elements per
// channel arrives as BEATS = SIZE/LANES beats; one result per channel leaves
// on a valid/ready stream one cycle after the final beat.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   mode                : MAX/AVG, sampled on the first beat of a window
//   in_valid/in_ready   : beat handshake; in_data channel c lane l at
//                         [(c*LANES+l)*W +: W]; in_last checked against count
//   out_valid/out_ready : result handshake; out_data channel c at [c*W +: W]
//   err_frame           : sticky framing error (in_last vs beat count)
module pooling_unit
  import pool_pkg::*;
#(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int CH    = 4,
  parameter int SIZE  = 16,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  pool_mode_e            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*LANES*(IL+FL)-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*(IL+FL)-1:0] out_data,
  output logic                  err_frame
);

  localparam int W     = IL + FL;
  localparam int BEATS = SIZE / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  pool_state_e       state_r;
  pool_state_e       state_nxt_s;
  logic [CW-1:0]     beat_cnt_r;
  pool_mode_e        mode_q_r;
  pool_mode_e        mode_eff_s;
  logic              run_r;
  logic              out_valid_r;
  logic [CH*W-1:0]   out_data_r;
  logic              err_frame_r;
  logic              accept_s;
  logic              first_s;
  logic              last_beat_s;
  logic [CH*W-1:0]   result_s;

  assign accept_s    = in_valid & in_ready;
  assign first_s     = (beat_cnt_r == {CW{1'b0}});
  assign last_beat_s = (beat_cnt_r == CW'(BEATS - 1));
  // The first beat uses the live mode; later beats use the latched one.
  assign mode_eff_s  = first_s ? mode : mode_q_r;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign err_frame = err_frame_r;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    pool_channel #(
      .W     (W),
      .LANES (LANES),
      .SIZE  (SIZE)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .lanes  (in_data[c*LANES*W +: LANES*W]),
      .first  (first_s),
      .mode   (mode_eff_s),
      .en     (accept_s),
      .result (result_s[c*W +: W])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a window closing while the previous result leaves keeps HOLD.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM: begin
        if (accept_s && last_beat_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (accept_s && last_beat_s) begin
          state_nxt_s = HOLD;
        end else if (out_ready) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = ACCUM;
    endcase
  end

  // FSM outputs: in HOLD a new beat may enter only as the result leaves.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      ACCUM:   in_ready = run_r;
      HOLD:    in_ready = run_r & out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Holds in_ready low until the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Beat counter and mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= {CW{1'b0}};
      mode_q_r   <= POOL_MAX;
    end else if (accept_s) begin
      beat_cnt_r <= last_beat_s ? {CW{1'b0}} : (beat_cnt_r + CW'(1));
      mode_q_r   <= mode_eff_s;
    end else begin
      beat_cnt_r <= beat_cnt_r;
      mode_q_r   <= mode_q_r;
    end
  end

  // Output register: loaded on the final beat, cleared when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(CH*W){1'b0}};
    end else if (accept_s && last_beat_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end

  // Sticky framing error; the window still closes on the beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frame_r <= 1'b0;
    end else if (accept_s && (in_last != last_beat_s)) begin
      err_frame_r <= 1'b1;
    end else begin
      err_frame_r <= err_frame_r;
    end
  end

endmodule

// File: tb/tb_pooling_unit.sv
module tb_pooling_unit;
  import pool_pkg::*;

  localparam int IL    = 4;
  localparam int FL    = 16;
  localparam int W     = IL + FL;
  localparam int CH    = 4;
  localparam int SIZE  = 16;
  localparam int LANES = 4;
  localparam int BEATS = SIZE / LANES;

  logic                    clk;
  logic                    rst_n;
  pool_mode_e              mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [CH*LANES*W-1:0]   in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH*W-1:0]         out_data;
  logic                    err_frame;

  pooling_unit #(
    .IL(IL), .FL(FL), .CH(CH), .SIZE(SIZE), .LANES(LANES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_frame (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  logic signed [W-1:0] win [CH][SIZE];
  logic [CH*W-1:0]     sb [$];
  logic [CH*W-1:0]     last_exp;
  bit  gap_en   = 1'b0;
  bit  have_prev = 1'b0;
  int  prev_cyc = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: max of all elements, or floor(sum / SIZE).
  function automatic logic [CH*W-1:0] calc_exp(input pool_mode_e m);
    logic [CH*W-1:0] r;
    longint s;
    longint mx;
    longint v;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      s  = 0;
      mx = longint'(win[c][0]);
      for (int i = 0; i < SIZE; i++) begin
        v = longint'(win[c][i]);
        s += v;
        if (v > mx) mx = v;
      end
      if (m == POOL_MAX) r[c*W +: W] = mx[W-1:0];
      else begin
        v = s >>> $clog2(SIZE);
        r[c*W +: W] = v[W-1:0];
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: compare every consumed result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", 128'(1), 128'(0));
      end else begin
        check_val("out_data", 128'(out_data), 128'(sb.pop_front()));
      end
      if (gap_en && have_prev) check_val("gap", 128'(cyc - prev_cyc), 128'(BEATS));
      have_prev = 1'b1;
      prev_cyc  = cyc;
    end
  end

  task automatic fill_random();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < SIZE; i++)
        win[c][i] = W'($urandom);
  endtask

  task automatic drive_beat(input int b, input pool_mode_e m, input bit last);
    for (int c = 0; c < CH; c++)
      for (int l = 0; l < LANES; l++)
        in_data[(c*LANES+l)*W +: W] = win[c][b*LANES+l];
    mode     = m;
    in_last  = last;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit acc = 1'b0;
    int t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check_val("accept_timeout", 128'(0), 128'(1));
  endtask

  // Sends nbeats beats; a complete window pushes its expected result.
  task automatic send_window(input pool_mode_e m, input int nbeats, input int lastpos,
                             input bit toggle, input int stall);
    pool_mode_e other;
    other = (m == POOL_MAX) ? POOL_AVG : POOL_MAX;
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(b, (b == 0 || !toggle) ? m : other, b == lastpos);
      if (b == 0 && stall > 0) begin
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          check_val("stall_in_ready", 128'(in_ready), 128'(0));
          check_val("stall_out_valid", 128'(out_valid), 128'(1));
          check_val("stall_out_data", 128'(out_data), 128'(last_exp));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      wait_accept();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (nbeats == BEATS) begin
      last_exp = calc_exp(m);
      sb.push_back(last_exp);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_val("drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0; mode = POOL_MAX; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 128'(in_ready), 128'(0));
    check_val("rst_out_valid", 128'(out_valid), 128'(0));
    check_val("rst_out_data", 128'(out_data), 128'(0));
    check_val("rst_err_frame", 128'(err_frame), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_release", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // 1: MAX of all-negative channel gives the largest negative, not 0.
    fill_random();
    for (int k = 0; k < SIZE; k++)
      win[0][k] = W'(-8 * 65536 + ((k * 7) % 16) * 32768);
    send_window(POOL_MAX, BEATS, BEATS-1, 1'b0, 0);
    @(negedge clk);
    check_val("latency_valid", 128'(out_valid), 128'(1));
    check_val("max_neg_ch0", 128'(out_data[W-1:0]), 128'(20'hF8000));
    drain();

    // 2: AVG exact values and floor on a single -1 LSB.
    fill_random();
    for (int k = 0; k < SIZE; k++) begin
      win[0][k] = W'((k + 1) * 16384);
      win[1][k] = W'(491520);
      win[2][k] = '0;
    end
    win[2][5] = '1;
    send_window(POOL_AVG, BEATS, BEATS-1, 1'b0, 0);
    @(negedge clk);
    check_val("avg_ramp_ch0", 128'(out_data[0*W +: W]), 128'(20'h22000));
    check_val("avg_const_ch1", 128'(out_data[1*W +: W]), 128'(20'h78000));
    check_val("avg_floor_ch2", 128'(out_data[2*W +: W]), 128'(20'hFFFFF));
    drain();

    // 3: backpressure holds the result and stalls the next window.
    out_ready = 1'b0;
    fill_random();
    send_window(POOL_AVG, BEATS, BEATS-1, 1'b0, 0);
    fill_random();
    send_window(POOL_MAX, BEATS, BEATS-1, 1'b0, 5);
    drain();

    // 4: continuous streaming, one result every BEATS cycles.
    have_prev = 1'b0;
    gap_en    = 1'b1;
    for (int w = 0; w < 4; w++) begin
      fill_random();
      send_window((w % 2 == 0) ? POOL_MAX : POOL_AVG, BEATS, BEATS-1, 1'b0, 0);
    end
    drain();
    gap_en = 1'b0;

    // 5: early in_last flags an error; mid-window mode toggle is ignored.
    check_val("err_before", 128'(err_frame), 128'(0));
    fill_random();
    send_window(POOL_AVG, BEATS, 2, 1'b1, 0);
    drain();
    check_val("err_after", 128'(err_frame), 128'(1));
    fill_random();
    send_window(POOL_MAX, BEATS, 2, 1'b1, 0);
    drain();

    // 6: reset discards a pending result and a partial window.
    out_ready = 1'b0;
    fill_random();
    send_window(POOL_MAX, BEATS, BEATS-1, 1'b0, 0);
    check_val("pending_valid", 128'(out_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    check_val("rst_drops_valid", 128'(out_valid), 128'(0));
    check_val("rst_clears_err", 128'(err_frame), 128'(0));
    sb.delete();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    fill_random();
    send_window(POOL_AVG, 2, BEATS-1, 1'b0, 0);
    fill_random();
    drive_beat(2, POOL_AVG, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_valid", 128'(out_valid), 128'(0));
    check_val("rst_mid_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random();
    send_window(POOL_AVG, BEATS, BEATS-1, 1'b0, 0);
    drain();
    check_val("err_clean", 128'(err_frame), 128'(0));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
